banked_mem_xbar_arbiter: RTL and testbench

Parametrised successor to the single-port-per-bank memory arbiter. NUM_MASTERS masters share NUM_BANKS word-interleaved on-chip SRAM banks through a crossbar. Each bank has its own round-robin arbiter, so masters hitting different banks proceed in parallel. Sits between CPU/DMA masters and local scratchpad; throughput is one access per bank per cycle.

---
 rtl/banked_mem_xbar_arbiter.sv | 134 +++++++++++++
 tb/tb_banked_mem_xbar_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_xbar_arbiter.sv
// Crossbar from NUM_MASTERS masters to NUM_BANKS word-interleaved SRAM banks, one round-robin arbiter per bank.
// Define MEM_ARB_STATS_EN to add the per-bank saturating contention counters (bank_conflicts).
module banked_mem_xbar_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int NUM_BANKS   = 4,
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int BANK_DEPTH  = 256
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_MASTERS-1:0]                 m_req,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr,
   input  logic [NUM_MASTERS-1:0]                 m_wr,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]                 m_gnt,
   output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata,
   output logic [NUM_MASTERS-1:0]                 m_rdy
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [NUM_BANKS-1:0][15:0]             bank_conflicts
`endif
);

   localparam int BS = $clog2(NUM_BANKS);
   localparam int RW = $clog2(BANK_DEPTH);
   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   // Handshake: a transfer occurs on the posedge where m_req & m_gnt; m_rdy pulses for one
   // cycle afterwards with the read data (or write echo), and m_rdata holds otherwise.

   logic [BS-1:0]          m_bank [NUM_MASTERS];
   logic [RW-1:0]          m_row  [NUM_MASTERS];
   logic [MW-1:0]          rr_ptr [NUM_BANKS];
   logic [MW-1:0]          g_idx  [NUM_BANKS];
   logic [NUM_BANKS-1:0]   g_vld;
   logic [NUM_MASTERS-1:0] won;
   logic [NUM_MASTERS-1:0] rdy_q;
   logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0]  mem [NUM_BANKS][BANK_DEPTH];

   always_comb begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
         m_bank[m] = m_addr[m][BS-1:0];
         m_row[m]  = m_addr[m][BS +: RW];
      end
   end

   // Search each bank upward from its pointer, wrapping; first matching requester wins.
   always_comb begin
      int idx;
      idx   = 0;
      won   = '0;
      g_vld = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         g_idx[b] = '0;
         for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (int'(rr_ptr[b]) + k) % NUM_MASTERS;
            if (!g_vld[b] && m_req[idx] && (m_bank[idx] == BS'(b))) begin
               g_vld[b]   = 1'b1;
               g_idx[b]   = MW'(idx);
               won[idx]   = 1'b1;
            end
         end
      end
   end

   assign m_gnt = {NUM_MASTERS{rst_n}} & m_req & won;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) rr_ptr[b] <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (g_vld[b])
               rr_ptr[b] <= (g_idx[b] == MW'(NUM_MASTERS - 1)) ? '0 : g_idx[b] + 1'b1;
         end
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (rst_n && g_vld[b] && m_wr[g_idx[b]])
            mem[b][m_row[g_idx[b]]] <= m_wdata[g_idx[b]];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdy_q   <= '0;
         rdata_q <= '0;
      end else begin
         for (int m = 0; m < NUM_MASTERS; m++) begin
            rdy_q[m] <= m_gnt[m];
            if (m_gnt[m])
               rdata_q[m] <= m_wr[m] ? m_wdata[m] : mem[m_bank[m]][m_row[m]];
         end
      end
   end

   // Gating by rst_n drops a response whose pulse would land in a reset cycle.
   assign m_rdy   = rdy_q & {NUM_MASTERS{rst_n}};
   assign m_rdata = rst_n ? rdata_q : '0;

`ifdef MEM_ARB_STATS_EN
   logic [NUM_BANKS-1:0] contended;

   always_comb begin
      int n;
      n         = 0;
      contended = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         n = 0;
         for (int m = 0; m < NUM_MASTERS; m++) begin
            if (m_req[m] && (m_bank[m] == BS'(b))) n = n + 1;
         end
         contended[b] = (n >= 2);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_conflicts <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (contended[b] && (bank_conflicts[b] != 16'hFFFF))
               bank_conflicts[b] <= bank_conflicts[b] + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_banked_mem_xbar_arbiter.sv
// Self-checking bench for banked_mem_xbar_arbiter (default parameters); a negedge monitor
// scoreboards every response against a reference memory model.
module tb_banked_mem_xbar_arbiter;

   localparam int NM = 4;
   localparam int NB = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int BD = 256;

   logic                   clk;
   logic                   rst_n;
   logic [NM-1:0]          m_req;
   logic [NM-1:0][AW-1:0]  m_addr;
   logic [NM-1:0]          m_wr;
   logic [NM-1:0][DW-1:0]  m_wdata;
   logic [NM-1:0]          m_gnt;
   logic [NM-1:0][DW-1:0]  m_rdata;
   logic [NM-1:0]          m_rdy;
`ifdef MEM_ARB_STATS_EN
   logic [NB-1:0][15:0]    bank_conflicts;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   banked_mem_xbar_arbiter #(
      .NUM_MASTERS(NM), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_DEPTH(BD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_addr(m_addr), .m_wr(m_wr),
      .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rdata(m_rdata), .m_rdy(m_rdy)
`ifdef MEM_ARB_STATS_EN
      , .bank_conflicts(bank_conflicts)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_q [NM][$];
   logic [DW-1:0] model_mem [NB][BD];
   logic [DW-1:0] last_rd [NM];
   logic [DW-1:0] exp_v;
   logic [NM-1:0] pend = '0;
   logic [1:0]    sb_bank;
   logic [7:0]    sb_row;
   int            per_bank;

   always @(negedge clk) begin
      if (!rst_n) begin
         n_checks++;
         if (m_rdy !== '0 || m_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b rdata=%h expected rdy=0 rdata=0", m_rdy, m_rdata);
         end
         for (int m = 0; m < NM; m++) begin
            exp_q[m].delete();
            last_rd[m] = '0;
         end
         pend = '0;
      end else begin
         for (int m = 0; m < NM; m++) begin
            n_checks++;
            if (m_rdy[m] !== pend[m]) begin
               n_fail++;
               $display("FAIL rdy_m%0d: got %b expected %b at %0t", m, m_rdy[m], pend[m], $time);
            end
            if (pend[m] && exp_q[m].size() > 0) last_rd[m] = exp_q[m].pop_front();
            n_checks++;
            if (m_rdata[m] !== last_rd[m]) begin
               n_fail++;
               $display("FAIL rdata_m%0d: got %h expected %h at %0t", m, m_rdata[m], last_rd[m], $time);
            end
         end
         n_checks++;
         if ((m_gnt & ~m_req) !== '0) begin
            n_fail++;
            $display("FAIL gnt_without_req: gnt=%b req=%b", m_gnt, m_req);
         end
         for (int b = 0; b < NB; b++) begin
            per_bank = 0;
            for (int m = 0; m < NM; m++)
               if (m_gnt[m] && m_addr[m][1:0] == 2'(b)) per_bank++;
            n_checks++;
            if (per_bank > 1) begin
               n_fail++;
               $display("FAIL one_grant_per_bank: bank %0d got %0d grants expected <=1", b, per_bank);
            end
         end
         pend = m_gnt;
         for (int m = 0; m < NM; m++) begin
            if (m_gnt[m]) begin
               sb_bank = m_addr[m][1:0];
               sb_row  = m_addr[m][9:2];
               if (m_wr[m]) begin
                  exp_q[m].push_back(m_wdata[m]);
                  model_mem[sb_bank][sb_row] = m_wdata[m];
               end else begin
                  exp_v = model_mem[sb_bank][sb_row];
                  exp_q[m].push_back(exp_v);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int m, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m_req[m]   = 1'b1;
      m_wr[m]    = wr;
      m_addr[m]  = a;
      m_wdata[m] = d;
   endtask

   task automatic idle_all();
      m_req = '0;
      m_wr  = '0;
   endtask

   task automatic check_gnt(input string name, input logic [NM-1:0] exp);
      #1;
      n_checks++;
      if (m_gnt !== exp) begin
         n_fail++;
         $display("FAIL %s: gnt=%b expected %b", name, m_gnt, exp);
      end
   endtask

   task automatic pulse_reset();
      step();
      idle_all();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      m_req = '1;
      check_gnt("gnt_forced_low_in_reset", 4'b0000);
      step();
      step();
      n_checks++;
      if (m_rdy !== '0 || m_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_state: rdy=%b rdata=%h expected 0", m_rdy, m_rdata);
      end
      idle_all();
      rst_n = 1'b1;
   endtask

   task automatic test_preload();
      for (int a = 0; a < 32; a++) begin
         step();
         idle_all();
         drive(0, 1'b1, AW'(a), $urandom);
         check_gnt("preload_gnt", 4'b0001);
      end
      step();
      idle_all();
   endtask

   task automatic test_write_read();
      step();
      drive(0, 1'b1, 16'h0004, 32'hDEADBEEF);
      check_gnt("wr_gnt_m0", 4'b0001);
      step();
      idle_all();
      drive(1, 1'b0, 16'h0004, 32'h0);
      #1;
      n_checks++;
      if (m_rdy[0] !== 1'b1 || m_rdata[0] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_echo_m0: rdy=%b rdata=%h expected 1 deadbeef", m_rdy[0], m_rdata[0]);
      end
      check_gnt("rd_gnt_m1", 4'b0010);
      step();
      idle_all();
      #1;
      n_checks++;
      if (m_rdy[1] !== 1'b1 || m_rdata[1] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL rd_data_m1: rdy=%b rdata=%h expected 1 deadbeef", m_rdy[1], m_rdata[1]);
      end
   endtask

   task automatic test_parallel();
      step();
      for (int m = 0; m < NM; m++) drive(m, 1'b0, AW'(m), 32'h0);
      check_gnt("parallel_gnt", 4'b1111);
      step();
      idle_all();
      #1;
      n_checks++;
      if (m_rdy !== 4'b1111) begin
         n_fail++;
         $display("FAIL parallel_rdy: rdy=%b expected 1111", m_rdy);
      end
   endtask

   task automatic test_round_robin();
      logic [NM-1:0] exp_seq [5];
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      pulse_reset();
      for (int m = 0; m < NM; m++) drive(m, 1'b0, AW'(4 * m), 32'h0);
      check_gnt("rr_gnt_0", exp_seq[0]);
      for (int i = 1; i < 5; i++) begin
         step();
         check_gnt($sformatf("rr_gnt_%0d", i), exp_seq[i]);
      end
      step();
      idle_all();
   endtask

   task automatic test_back_to_back();
      step();
      drive(2, 1'b1, 16'h0011, 32'h12345678);
      check_gnt("b2b_wr_gnt", 4'b0100);
      step();
      drive(2, 1'b0, 16'h0011, 32'h0);
      check_gnt("b2b_rd_gnt", 4'b0100);
      step();
      idle_all();
      #1;
      n_checks++;
      if (m_rdy[2] !== 1'b1 || m_rdata[2] !== 32'h12345678) begin
         n_fail++;
         $display("FAIL b2b_rd_data: rdy=%b rdata=%h expected 1 12345678", m_rdy[2], m_rdata[2]);
      end
   endtask

   task automatic test_reset_inflight();
      step();
      drive(0, 1'b0, 16'h0000, 32'h0);
      check_gnt("inflight_gnt", 4'b0001);
      step();
      idle_all();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (m_rdy !== '0 || m_rdata !== '0) begin
         n_fail++;
         $display("FAIL inflight_discard: rdy=%b rdata=%h expected 0", m_rdy, m_rdata);
      end
      step();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (m_rdy !== '0 || m_rdata !== '0) begin
         n_fail++;
         $display("FAIL post_reset_regs: rdy=%b rdata=%h expected 0", m_rdy, m_rdata);
      end
      for (int m = 0; m < NM; m++) drive(m, 1'b0, AW'(4 * m), 32'h0);
      check_gnt("post_reset_rr_0", 4'b0001);
      step();
      check_gnt("post_reset_rr_1", 4'b0010);
      step();
      idle_all();
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         step();
         for (int m = 0; m < NM; m++) begin
            m_req[m]   = 1'($urandom_range(0, 1));
            m_wr[m]    = 1'($urandom_range(0, 1));
            m_addr[m]  = AW'($urandom_range(0, 31));
            m_wdata[m] = $urandom;
         end
      end
      step();
      idle_all();
      step();
   endtask

`ifdef MEM_ARB_STATS_EN
   task automatic test_stats();
      pulse_reset();
      #1;
      n_checks++;
      if (bank_conflicts !== '0) begin
         n_fail++;
         $display("FAIL stats_reset: got %h expected 0", bank_conflicts);
      end
      drive(0, 1'b0, 16'h0002, 32'h0);
      drive(1, 1'b0, 16'h0006, 32'h0);
      drive(2, 1'b0, 16'h000A, 32'h0);
      step();
      step();
      step();
      idle_all();
      #1;
      n_checks++;
      if (bank_conflicts[2] !== 16'd3 || bank_conflicts[0] !== 16'd0) begin
         n_fail++;
         $display("FAIL stats_count: bank2=%0d bank0=%0d expected 3 0", bank_conflicts[2], bank_conflicts[0]);
      end
      drive(0, 1'b0, 16'h0002, 32'h0);
      drive(1, 1'b0, 16'h0006, 32'h0);
      repeat (65540) step();
      idle_all();
      #1;
      n_checks++;
      if (bank_conflicts[2] !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL stats_saturate: got %h expected ffff", bank_conflicts[2]);
      end
      pulse_reset();
      #1;
      n_checks++;
      if (bank_conflicts !== '0) begin
         n_fail++;
         $display("FAIL stats_clear: got %h expected 0", bank_conflicts);
      end
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      m_req   = '0;
      m_wr    = '0;
      m_addr  = '0;
      m_wdata = '0;
      test_reset();
      test_preload();
      test_write_read();
      test_parallel();
      test_round_robin();
      test_back_to_back();
      test_reset_inflight();
      test_random();
`ifdef MEM_ARB_STATS_EN
      test_stats();
`endif
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
